// File: rtl/hdc_pkg.sv
// hdc_pkg
//   Shared definitions for the HDC encoder datapath: hypervector geometry,
//   binder pack defaults, and the encoder-scheduler FSM state type.
//   No ports; imported by the encoder blocks.
package hdc_pkg;

    localparam int HV_DIM          = 1024;  // hypervector width in bits
    localparam int FEATURES_PER_CC = 8;     // features bound per pack per cycle
    localparam int SHIFTS          = 8;     // rotation steps available to a binder
    localparam int NUM_PACKS_DEF   = 6;     // default binder packs per sample

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } enc_sched_state_t;

    // Index width that never collapses to zero bits for a single pack.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/enc_sched_lat_pipe.sv
// enc_sched_lat_pipe
//   LAT-deep valid + index delay line that mirrors the binder register depth,
//   so a pack issued in cycle t reports its chunk in cycle t+LAT.
// Ports
//   clk, nrst        clock, async active-low reset
//   flush            synchronous clear of all valid bits
//   in_valid/in_idx  pack issued this cycle
//   out_valid/out_idx chunk whose shifted_hv is valid this cycle
//   empty            no chunk in flight (all stages invalid)
module enc_sched_lat_pipe #(
    parameter int LAT   = 1,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             empty
);

    logic [LAT-1:0]            vld_q;
    logic [LAT-1:0][IDX_W-1:0] idx_q;

    // Stage 0 is the live input; stage k is the registered copy k cycles later.
    logic [LAT:0]              vld_pipe;
    logic [LAT:0][IDX_W-1:0]   idx_pipe;

    assign vld_pipe = {vld_q, in_valid};
    assign idx_pipe = {idx_q, in_idx};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_q <= '0;
            idx_q <= '0;
        end else if (flush) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_pipe[LAT-1:0];
            idx_q <= idx_pipe[LAT-1:0];
        end
    end

    assign out_valid = vld_pipe[LAT];
    assign out_idx   = idx_pipe[LAT];
    assign empty     = ~|vld_q;

endmodule

// File: rtl/enc_bind_scheduler.sv
// enc_bind_scheduler
//   Walks NUM_PACKS binder packs one per cycle for a loaded sample, stalling
//   on !acc_ready, and reports each pack's chunk to the bundler BIND_LAT
//   cycles after issue. FSM IDLE -> ISSUE -> DRAIN -> IDLE.
// Ports
//   clk, nrst              clock, async active-low reset
//   start_req / start_ack  loader handshake (ack only in IDLE)
//   sw_clear               synchronous abort, flushes in-flight chunks
//   acc_ready              bundler can take issues; low stalls issue only
//   bind_start, pack_en    pack start and one-hot pack select
//   chunk_valid, chunk_idx chunk emerging from the binders this cycle
//   busy, done             sample in progress / pulse with last chunk
// Option
//   ENC_SCHED_PERF_EN adds saturating perf_stall_cnt and perf_sample_cnt.
module enc_bind_scheduler
    import hdc_pkg::*;
#(
    parameter int NUM_PACKS = NUM_PACKS_DEF,
    parameter int BIND_LAT  = 1,
    parameter int IDX_W     = idx_width(NUM_PACKS)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 start_req,
    output logic                 start_ack,
    input  logic                 sw_clear,
    input  logic                 acc_ready,
    output logic                 bind_start,
    output logic [NUM_PACKS-1:0] pack_en,
    output logic                 chunk_valid,
    output logic [IDX_W-1:0]     chunk_idx,
    output logic                 busy,
    output logic                 done
`ifdef ENC_SCHED_PERF_EN
    ,
    output logic [15:0]          perf_stall_cnt,
    output logic [15:0]          perf_sample_cnt
`endif
);

    // One extra bit so the count never wraps when NUM_PACKS is a power of two.
    localparam int              CNT_W    = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PACKS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PACKS - 1);

    enc_sched_state_t state;
    logic [CNT_W-1:0] issue_cnt;
    logic             issue;
    logic             pipe_empty;

    // An abort cycle never launches a pack, so nothing of the dead sample enters the pipe.
    assign issue      = (state == ISSUE) && acc_ready && !sw_clear;
    assign bind_start = issue;

    // Gated by nrst so every output reads 0 while reset is held.
    assign start_ack  = nrst && (state == IDLE) && start_req && !sw_clear;
    assign busy       = (state != IDLE);
    assign done       = (state == DRAIN) && chunk_valid && (chunk_idx == LAST_IDX) && !sw_clear;

    always_comb begin
        pack_en = '0;
        if (issue) pack_en[issue_cnt[IDX_W-1:0]] = 1'b1;
    end

    enc_sched_lat_pipe #(
        .LAT   (BIND_LAT),
        .IDX_W (IDX_W)
    ) u_lat_pipe (
        .clk       (clk),
        .nrst      (nrst),
        .flush     (sw_clear),
        .in_valid  (issue),
        .in_idx    (issue_cnt[IDX_W-1:0]),
        .out_valid (chunk_valid),
        .out_idx   (chunk_idx),
        .empty     (pipe_empty)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            issue_cnt <= '0;
        end else if (sw_clear) begin
            state     <= IDLE;
            issue_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ack) begin
                        state     <= ISSUE;
                        issue_cnt <= '0;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        issue_cnt <= issue_cnt + 1'b1;
                        if (issue_cnt == LAST_CNT) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // pipe_empty only guards against a lost last chunk.
                    if (done || pipe_empty) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ENC_SCHED_PERF_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            perf_stall_cnt  <= '0;
            perf_sample_cnt <= '0;
        end else begin
            if ((state == ISSUE) && !acc_ready && (perf_stall_cnt != 16'hFFFF))
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
            if (done && (perf_sample_cnt != 16'hFFFF))
                perf_sample_cnt <= perf_sample_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_enc_bind_scheduler.sv
// tb_enc_bind_scheduler
//   Directed bench for enc_bind_scheduler (NUM_PACKS=6, BIND_LAT=1): a
//   per-cycle vector table for the plain and stalled samples, plus sequences
//   for held start_req, sw_clear abort and asynchronous reset mid-issue.
module tb_enc_bind_scheduler;

    logic       clk = 1'b0;
    logic       nrst;
    logic       start_req, sw_clear, acc_ready;
    logic       start_ack, bind_start, chunk_valid, busy, done;
    logic [5:0] pack_en;
    logic [2:0] chunk_idx;
`ifdef ENC_SCHED_PERF_EN
    logic [15:0] perf_stall_cnt, perf_sample_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    enc_bind_scheduler #(.NUM_PACKS(6), .BIND_LAT(1)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .start_req   (start_req),
        .start_ack   (start_ack),
        .sw_clear    (sw_clear),
        .acc_ready   (acc_ready),
        .bind_start  (bind_start),
        .pack_en     (pack_en),
        .chunk_valid (chunk_valid),
        .chunk_idx   (chunk_idx),
        .busy        (busy),
        .done        (done)
`ifdef ENC_SCHED_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_sample_cnt (perf_sample_cnt)
`endif
    );

    typedef struct {
        bit       req, rdy, clr;
        bit       ack, bs;
        bit [5:0] pe;
        bit       cv;
        bit [2:0] ci;
        bit       busy, done;
    } vec_t;

    function automatic vec_t v(input bit req, rdy, clr, ack, bs, input bit [5:0] pe,
                               input bit cv, input bit [2:0] ci, input bit bz, dn);
        vec_t r;
        r.req = req; r.rdy = rdy; r.clr = clr; r.ack = ack; r.bs = bs;
        r.pe = pe; r.cv = cv; r.ci = ci; r.busy = bz; r.done = dn;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit a, input bit c);
        start_req = r; acc_ready = a; sw_clear = c;
    endtask

    // Drive just after the rising edge, leave the sample point 4 ns later.
    task automatic step(input bit r, input bit a, input bit c);
        @(posedge clk);
        #1 drive(r, a, c);
        #3;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " start_ack"},   int'(start_ack),   0);
        check({tag, " bind_start"},  int'(bind_start),  0);
        check({tag, " pack_en"},     int'(pack_en),     0);
        check({tag, " chunk_valid"}, int'(chunk_valid), 0);
        check({tag, " busy"},        int'(busy),        0);
        check({tag, " done"},        int'(done),        0);
    endtask

    // Sample was accepted on the previous step; expect done 7 cycles after accept.
    task automatic run_sample(input string tag);
        int done_cyc = -1;
        int n_cv = 0;
        int next_idx = 0;
        int order_bad = 0;
        for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
            step(0, 1, 0);
            if (chunk_valid) begin
                if (int'(chunk_idx) != next_idx) order_bad++;
                next_idx++;
                n_cv++;
            end
            if (done) done_cyc = c;
        end
        check({tag, " done cycle"},  done_cyc,  7);
        check({tag, " chunk count"}, n_cv,      6);
        check({tag, " chunk order"}, order_bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int   ack2, done_cyc, quiet_bad;

        // Sample 1: plain run, start_req for one cycle.
        tbl.push_back(v(1,1,0, 1,0,6'h00, 0,0, 0,0));
        tbl.push_back(v(0,1,0, 0,1,6'h01, 0,0, 1,0));
        tbl.push_back(v(0,1,0, 0,1,6'h02, 1,0, 1,0));
        tbl.push_back(v(0,1,0, 0,1,6'h04, 1,1, 1,0));
        tbl.push_back(v(0,1,0, 0,1,6'h08, 1,2, 1,0));
        tbl.push_back(v(0,1,0, 0,1,6'h10, 1,3, 1,0));
        tbl.push_back(v(0,1,0, 0,1,6'h20, 1,4, 1,0));
        tbl.push_back(v(0,1,0, 0,0,6'h00, 1,5, 1,1));
        tbl.push_back(v(0,1,0, 0,0,6'h00, 0,0, 0,0));
        // Sample 2: acc_ready low for two ISSUE cycles.
        tbl.push_back(v(1,1,0, 1,0,6'h00, 0,0, 0,0));
        tbl.push_back(v(0,1,0, 0,1,6'h01, 0,0, 1,0));
        tbl.push_back(v(0,1,0, 0,1,6'h02, 1,0, 1,0));
        tbl.push_back(v(0,0,0, 0,0,6'h00, 1,1, 1,0));
        tbl.push_back(v(0,0,0, 0,0,6'h00, 0,0, 1,0));
        tbl.push_back(v(0,1,0, 0,1,6'h04, 0,0, 1,0));
        tbl.push_back(v(0,1,0, 0,1,6'h08, 1,2, 1,0));
        tbl.push_back(v(0,1,0, 0,1,6'h10, 1,3, 1,0));
        tbl.push_back(v(0,1,0, 0,1,6'h20, 1,4, 1,0));
        tbl.push_back(v(0,1,0, 0,0,6'h00, 1,5, 1,1));
        tbl.push_back(v(0,1,0, 0,0,6'h00, 0,0, 0,0));

        // Reset state, with start_req already asserted.
        nrst = 1'b0;
        drive(1, 1, 0);
        #2 check_all_zero("reset");
        #20 nrst = 1'b1;
        drive(0, 1, 0);
        step(0, 1, 0);
        check("post-reset busy", int'(busy), 0);

        foreach (tbl[i]) begin
            step(tbl[i].req, tbl[i].rdy, tbl[i].clr);
            check($sformatf("v%0d start_ack", i),  int'(start_ack),  int'(tbl[i].ack));
            check($sformatf("v%0d bind_start", i), int'(bind_start), int'(tbl[i].bs));
            check($sformatf("v%0d pack_en", i),    int'(pack_en),    int'(tbl[i].pe));
            check($sformatf("v%0d chunk_valid", i),int'(chunk_valid),int'(tbl[i].cv));
            if (tbl[i].cv)
                check($sformatf("v%0d chunk_idx", i), int'(chunk_idx), int'(tbl[i].ci));
            check($sformatf("v%0d busy", i),       int'(busy),       int'(tbl[i].busy));
            check($sformatf("v%0d done", i),       int'(done),       int'(tbl[i].done));
        end

`ifdef ENC_SCHED_PERF_EN
        check("perf_stall_cnt",  int'(perf_stall_cnt),  2);
        check("perf_sample_cnt", int'(perf_sample_cnt), 2);
`endif

        // start_req held: next ack only in the IDLE cycle after done.
        step(1, 1, 0);
        check("held ack first", int'(start_ack), 1);
        ack2 = -1; done_cyc = -1;
        for (int c = 1; c <= 12 && ack2 < 0; c++) begin
            step(1, 1, 0);
            if (done) done_cyc = c;
            if (start_ack) ack2 = c;
        end
        check("held done cycle",  done_cyc, 7);
        check("held second ack",  ack2,     8);

        // sw_clear at t4 of the sample accepted above.
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 1);
        check("clr t4 done", int'(done), 0);
        step(0, 1, 0);
        check("clr t5 busy",        int'(busy),        0);
        check("clr t5 chunk_valid", int'(chunk_valid), 0);
        quiet_bad = 0;
        for (int c = 0; c < 6; c++) begin
            step(0, 1, 0);
            if (chunk_valid || done || busy || bind_start) quiet_bad++;
        end
        check("clr quiet cycles", quiet_bad, 0);
        // sw_clear and start_req together in IDLE: no accept.
        step(1, 1, 1);
        check("clr+req ack", int'(start_ack), 0);
        step(0, 1, 0);
        check("clr+req busy", int'(busy), 0);
        step(1, 1, 0);
        check("after clr ack", int'(start_ack), 1);
        run_sample("after clr");

        // Asynchronous reset in the middle of ISSUE.
        step(0, 1, 0);
        step(1, 1, 0);
        check("rst run ack", int'(start_ack), 1);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        #2 nrst = 1'b0;
        start_req = 1'b1;
        #1 check_all_zero("async rst");
        @(posedge clk);
        #3 nrst = 1'b1;
        drive(0, 1, 0);
        step(0, 1, 0);
        check("rst release busy",        int'(busy),        0);
        check("rst release chunk_valid", int'(chunk_valid), 0);
        step(1, 1, 0);
        check("rst release ack", int'(start_ack), 1);
        run_sample("after rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
